// File: rtl/acsu_pm_bank.sv
// acsu_pm_bank: Viterbi add-compare-select with path-metric bank; define ACSU_NORM_EN to enable MSB normalisation
module acsu_pm_bank #(
  parameter int K = 3,
  parameter logic [K-1:0] G0 = 3'o7,
  parameter logic [K-1:0] G1 = 3'o5,
  parameter int BM_W = 2,
  parameter int PM_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [4*BM_W-1:0]     i_bm,
  output logic                  o_valid,
  output logic [2**(K-1)-1:0]   o_decision,
  output logic [K-2:0]          o_best_state,
  output logic [PM_W-1:0]       o_pm_min,
  output logic                  o_norm
);
  localparam int NS = 2 ** (K - 1);
  logic [PM_W-1:0] pm [NS];
  logic [PM_W-1:0] sel [NS];
  logic [PM_W-1:0] nxt [NS];
  logic [NS-1:0] dec;
  logic [K-2:0] best;
  logic [PM_W-1:0] mn;
  logic [PM_W-1:0] mn_n;
  logic norm;
  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam logic [K-2:0] S = (K-1)'(n);
    localparam logic [K-2:0] P0 = {S[K-3:0], 1'b0};
    localparam logic [K-2:0] P1 = {S[K-3:0], 1'b1};
    localparam logic [K-1:0] T0 = {S[K-2], P0};
    localparam logic [K-1:0] T1 = {S[K-2], P1};
    localparam logic [1:0] B0 = {^(G0 & T0), ^(G1 & T0)};
    localparam logic [1:0] B1 = {^(G0 & T1), ^(G1 & T1)};
    logic [PM_W:0] s0, s1;
    logic [PM_W-1:0] m0, m1;
    assign s0 = {1'b0, pm[P0]} + {{(PM_W+1-BM_W){1'b0}}, i_bm[B0*BM_W +: BM_W]};
    assign s1 = {1'b0, pm[P1]} + {{(PM_W+1-BM_W){1'b0}}, i_bm[B1*BM_W +: BM_W]};
    assign m0 = s0[PM_W] ? '1 : s0[PM_W-1:0];
    assign m1 = s1[PM_W] ? '1 : s1[PM_W-1:0];
    assign dec[n] = m1 < m0;
    assign sel[n] = dec[n] ? m1 : m0;
  end
  // minimum search over the selected metrics, lowest index wins ties
  always_comb begin
    best = '0;
    mn = sel[0];
    for (int s = 1; s < NS; s++) begin
      if (sel[s] < mn) begin
        mn = sel[s];
        best = (K-1)'(s);
      end
    end
  end
`ifdef ACSU_NORM_EN
  assign norm = mn[PM_W-1];
`else
  assign norm = 1'b0;
`endif
  assign mn_n = norm ? {1'b0, mn[PM_W-2:0]} : mn;
  // clearing every MSB once the minimum has it set subtracts 2^(PM_W-1) from all metrics
  always_comb begin
    for (int s = 0; s < NS; s++) nxt[s] = norm ? {1'b0, sel[s][PM_W-2:0]} : sel[s];
  end
  // path-metric bank and registered step outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NS; s++) pm[s] <= (s == 0) ? '0 : '1;
      o_valid <= 1'b0;
      o_decision <= '0;
      o_best_state <= '0;
      o_pm_min <= '0;
      o_norm <= 1'b0;
    end else if (i_start) begin
      for (int s = 0; s < NS; s++) pm[s] <= (s == 0) ? '0 : '1;
      o_valid <= 1'b0;
    end else if (i_valid) begin
      for (int s = 0; s < NS; s++) pm[s] <= nxt[s];
      o_valid <= 1'b1;
      o_decision <= dec;
      o_best_state <= best;
      o_pm_min <= mn_n;
      o_norm <= norm;
    end else begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_acsu_pm_bank.sv
// tb_acsu_pm_bank: scoreboard bench for acsu_pm_bank against a behavioural trellis model
module tb_acsu_pm_bank;
  localparam int K = 3;
  localparam int NST = 4;
  localparam int G0 = 7;
  localparam int G1 = 5;
  localparam int BM_W = 2;
  localparam int PM_W = 4;
  localparam int PMAX = 15;
  localparam int HALF = 8;
`ifdef ACSU_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, start, valid;
  logic [7:0] bm;
  logic o_valid, o_norm;
  logic [3:0] o_decision;
  logic [1:0] o_best_state;
  logic [3:0] o_pm_min;
  int checks = 0;
  int failures = 0;
  typedef struct { int dec; int best; int mn; int nrm; } exp_t;
  exp_t q[$];
  int mpm[NST];

  acsu_pm_bank #(.K(K), .G0(3'o7), .G1(3'o5), .BM_W(BM_W), .PM_W(PM_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid), .i_bm(bm),
    .o_valid(o_valid), .o_decision(o_decision), .o_best_state(o_best_state),
    .o_pm_min(o_pm_min), .o_norm(o_norm));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_init();
    for (int s = 0; s < NST; s++) mpm[s] = (s == 0) ? 0 : PMAX;
  endtask

  task automatic model_step(input logic [7:0] b);
    int nm[NST];
    int dec[NST];
    exp_t e;
    for (int s = 0; s < NST; s++) begin nm[s] = 1 << 30; dec[s] = 0; end
    for (int s = 0; s < NST; s++) begin
      for (int u = 0; u < 2; u++) begin
        int full, c0, c1, sym, w, c, ns;
        full = (u << (K - 1)) | s;
        c0 = $countones(G0 & full) & 1;
        c1 = $countones(G1 & full) & 1;
        sym = c0 * 2 + c1;
        w = (b >> (sym * BM_W)) & 3;
        c = mpm[s] + w;
        if (c > PMAX) c = PMAX;
        ns = (u << (K - 2)) | (s >> 1);
        if (c < nm[ns]) begin nm[ns] = c; dec[ns] = s & 1; end
      end
    end
    e.mn = nm[0]; e.best = 0; e.nrm = 0; e.dec = 0;
    for (int s = 1; s < NST; s++) if (nm[s] < e.mn) begin e.mn = nm[s]; e.best = s; end
    if (NORM && e.mn >= HALF) begin
      e.nrm = 1;
      e.mn -= HALF;
      for (int s = 0; s < NST; s++) nm[s] -= HALF;
    end
    for (int s = 0; s < NST; s++) begin mpm[s] = nm[s]; e.dec |= dec[s] << s; end
    q.push_back(e);
  endtask

  // reference model advances on the same edges the design accepts work on
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin model_init(); q.delete(); end
    else if (start) model_init();
    else if (valid) model_step(bm);
  end

  // monitor: every output pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("decision", int'(o_decision), e.dec);
        chk("best_state", int'(o_best_state), e.best);
        chk("pm_min", int'(o_pm_min), e.mn);
        chk("norm", int'(o_norm), e.nrm);
      end
    end
  end

  task automatic drive(input logic s, input logic v, input logic [7:0] b);
    @(negedge clk);
    start = s; valid = v; bm = b;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(o_valid), 0);
    chk({tag, "_decision"}, int'(o_decision), 0);
    chk({tag, "_best"}, int'(o_best_state), 0);
    chk({tag, "_pm_min"}, int'(o_pm_min), 0);
    chk({tag, "_norm"}, int'(o_norm), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; bm = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_valid", int'(o_valid), 0);
    end
    drive(1, 0, 8'h00);
    drive(0, 1, 8'hA8);
    drive(0, 0, 8'h00);
    chk("first_min", int'(o_pm_min), 0);
    chk("first_dec", int'(o_decision), 0);
    chk("first_best", int'(o_best_state), 0);
    drive(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'hFF);
      if (i == 2) chk("all3_step2_min", int'(o_pm_min), 6);
    end
    drive(0, 0, 8'h00);
    chk("all3_step3_min", int'(o_pm_min), NORM ? 1 : 9);
    chk("all3_step3_norm", int'(o_norm), NORM ? 1 : 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 8'hFF);
    drive(0, 0, 8'h00);
`ifndef ACSU_NORM_EN
    chk("saturated_min", int'(o_pm_min), PMAX);
`endif
    drive(1, 1, 8'hFF);
    drive(0, 0, 8'h00);
    chk("start_priority_valid", int'(o_valid), 0);
    drive(0, 1, 8'hA8);
    drive(0, 0, 8'h00);
    chk("after_start_min", int'(o_pm_min), 0);
    drive(0, 1, 8'hA8);
    drive(0, 1, 8'hFF);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    drive(0, 1, 8'hA8);
    drive(0, 0, 8'h00);
    chk("post_reset_min", int'(o_pm_min), 0);
    chk("post_reset_dec", int'(o_decision), 0);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 8'($urandom));
    repeat (3) drive(0, 0, 8'h00);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
